// File: rtl/global_io_mp.sv
// Multi-slice global I/O combiner: shift-weights SLICES MAC partial sums per beat and
// shift-accumulates them MSB-first over a framed bit-serial activation stream.

module global_io_mp_slice #(
    parameter int MAC_W     = 15,
    parameter int SHIFT_AMT = 0,
    parameter int COMB_W    = 29
) (
    input  logic [MAC_W-1:0]  slice,
    input  logic              active,
    input  logic              negate,
    output logic [COMB_W-1:0] term
);
    logic [COMB_W-1:0] mag;

    assign mag  = {{(COMB_W-MAC_W){1'b0}}, slice} << SHIFT_AMT;
    assign term = !active ? '0 : (negate ? ('0 - mag) : mag);
endmodule

module global_io_mp #(
    parameter int MAC_W  = 15,
    parameter int SLICES = 2,
    parameter int SHIFT  = 12,
    parameter int ACC_W  = 51,
    parameter int NSL_W  = $clog2(SLICES+1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [SLICES*MAC_W-1:0] macout,
    input  logic [NSL_W-1:0]        nsl,
    input  logic                    w_signed,
    input  logic                    x_signed,
    output logic signed [ACC_W-1:0] nout,
    output logic                    out_valid,
    output logic                    out_ovf,
    output logic                    proto_err
);
    localparam int COMB_W = MAC_W + SHIFT*(SLICES-1) + 2;

    logic [1:0]              vld_pipe;
    logic                    frame_open;
    logic [NSL_W-1:0]        nsl_clamp, cfg_nsl;
    logic                    cfg_ws, cfg_xs;
    logic                    accept;

    logic [SLICES*MAC_W-1:0] a_mac;
    logic                    a_first, a_last, a_ws, a_xs;
    logic [NSL_W-1:0]        a_nsl;

    logic [SLICES-1:0][COMB_W-1:0] terms;
    logic [SLICES-1:0]       act, neg;
    logic [COMB_W-1:0]       comb, b_comb;
    logic                    b_first, b_last, b_xs;

    logic [ACC_W-1:0]        acc, acc_next, shw;
    logic [ACC_W:0]          comb_x, ex;
    logic                    ovf, ovf_next, ovf_step;

    always_comb begin
        nsl_clamp = nsl;
        if (nsl == '0)
            nsl_clamp = NSL_W'(1);
        else if (nsl > NSL_W'(SLICES))
            nsl_clamp = NSL_W'(SLICES);
    end

    assign accept = in_valid && (in_first || frame_open);

    // Framing and config capture; config rides with each beat so back-to-back
    // frames never see each other's settings downstream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_open <= 1'b0;
            proto_err  <= 1'b0;
            cfg_nsl    <= '0;
            cfg_ws     <= 1'b0;
            cfg_xs     <= 1'b0;
        end else if (in_valid) begin
            if (in_first) begin
                frame_open <= !in_last;
                cfg_nsl    <= nsl_clamp;
                cfg_ws     <= w_signed;
                cfg_xs     <= x_signed;
                if (frame_open)
                    proto_err <= 1'b1;
            end else if (frame_open) begin
                if (in_last)
                    frame_open <= 1'b0;
            end else begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            a_mac    <= '0;
            a_first  <= 1'b0;
            a_last   <= 1'b0;
            a_nsl    <= '0;
            a_ws     <= 1'b0;
            a_xs     <= 1'b0;
            b_comb   <= '0;
            b_first  <= 1'b0;
            b_last   <= 1'b0;
            b_xs     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            if (accept) begin
                a_mac   <= macout;
                a_first <= in_first;
                a_last  <= in_last;
                a_nsl   <= in_first ? nsl_clamp : cfg_nsl;
                a_ws    <= in_first ? w_signed  : cfg_ws;
                a_xs    <= in_first ? x_signed  : cfg_xs;
            end
            if (vld_pipe[0]) begin
                b_comb  <= comb;
                b_first <= a_first;
                b_last  <= a_last;
                b_xs    <= a_xs;
            end
        end
    end

    for (genvar g = 0; g < SLICES; g++) begin : g_slice
        assign act[g] = a_nsl > NSL_W'(g);
        assign neg[g] = a_ws && (a_nsl == NSL_W'(g+1));
        global_io_mp_slice #(
            .MAC_W(MAC_W), .SHIFT_AMT(g*SHIFT), .COMB_W(COMB_W)
        ) u_slice (
            .slice (a_mac[g*MAC_W +: MAC_W]),
            .active(act[g]),
            .negate(neg[g]),
            .term  (terms[g])
        );
    end

    always_comb begin
        comb = '0;
        for (int i = 0; i < SLICES; i++)
            comb = comb + terms[i];
    end

    // One extra guard bit exposes overflow of the negate/add; the shift overflows
    // when the two top accumulator bits differ.
    assign comb_x = {{(ACC_W-COMB_W+1){b_comb[COMB_W-1]}}, b_comb};

    always_comb begin
        shw      = {acc[ACC_W-2:0], 1'b0};
        ovf_step = 1'b0;
        if (b_first) begin
            ex = b_xs ? ('0 - comb_x) : comb_x;
        end else begin
            ex       = {shw[ACC_W-1], shw} + comb_x;
            ovf_step = acc[ACC_W-1] ^ acc[ACC_W-2];
        end
        acc_next = ex[ACC_W-1:0];
        ovf_next = (!b_first && ovf) || ovf_step || (ex[ACC_W] ^ ex[ACC_W-1]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc       <= '0;
            ovf       <= 1'b0;
            nout      <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= vld_pipe[1] && b_last;
            if (vld_pipe[1]) begin
                acc <= acc_next;
                ovf <= ovf_next;
                if (b_last) begin
                    nout    <= acc_next;
                    out_ovf <= ovf_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_global_io_mp.sv
// Directed bench for global_io_mp: hand-computed results, latency, framing errors, reset.

module tb_global_io_mp;
    logic               clk = 1'b0;
    logic               rstn;
    logic               in_valid, in_first, in_last;
    logic [29:0]        macout;
    logic [1:0]         nsl;
    logic               w_signed, x_signed;
    logic signed [50:0] nout;
    logic               out_valid, out_ovf, proto_err;

    int tests  = 0;
    int failed = 0;
    int pulses = 0;
    int p;
    logic signed [50:0] q_nout[$];
    logic               q_ovf[$];
    longint             ovf_exp;

    global_io_mp dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .macout(macout), .nsl(nsl), .w_signed(w_signed),
        .x_signed(x_signed), .nout(nout), .out_valid(out_valid),
        .out_ovf(out_ovf), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            pulses++;
            q_nout.push_back(nout);
            q_ovf.push_back(out_ovf);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic f, input logic l, input logic [1:0] ns, input logic ws,
                        input logic xs, input logic [14:0] s0, input logic [14:0] s1);
        in_valid = 1'b1; in_first = f; in_last = l; nsl = ns;
        w_signed = ws; x_signed = xs; macout = {s1, s0};
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Non-first beats drive junk config to show the frame config is held.
    task automatic frame(input int n, input logic [1:0] ns, input logic ws, input logic xs,
                         input logic [14:0] s0, input logic [14:0] s1);
        for (int i = 0; i < n; i++)
            beat(i == 0, i == n-1, (i == 0) ? ns : 2'd0, (i == 0) ? ws : ~ws,
                 (i == 0) ? xs : ~xs, s0, s1);
    endtask

    task automatic wait_for(input int target);
        for (int i = 0; i < 20 && pulses < target; i++) @(negedge clk);
        chk("pulse_count", pulses, target);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        macout = '0; nsl = '0; w_signed = 1'b0; x_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_nout", nout, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_proto_err", proto_err, 0);
        rstn = 1'b1;
        @(negedge clk);

        // single-beat frame, latency 3 edges, slice1 ignored
        beat(1, 1, 2'd1, 0, 0, 15'd100, 15'd777);
        chk("lat_k0", out_valid, 0);
        @(negedge clk); chk("lat_k1", out_valid, 0);
        @(negedge clk); chk("lat_k2", out_valid, 1);
        chk("single_nout", nout, 100);
        chk("single_ovf", out_ovf, 0);
        @(negedge clk); chk("lat_k3", out_valid, 0);
        chk("single_hold", nout, 100);

        p = pulses; frame(1, 2'd2, 0, 0, 15'd5, 15'd3); wait_for(p+1);
        chk("two_slice_u", q_nout[p], 12293);
        p = pulses; frame(1, 2'd2, 1, 0, 15'd5, 15'd3); wait_for(p+1);
        chk("two_slice_ws", q_nout[p], -12283);

        p = pulses; frame(4, 2'd1, 0, 1, 15'd1, 15'd5); wait_for(p+1);
        chk("four_beat_xs", q_nout[p], -1);
        p = pulses; frame(4, 2'd1, 0, 0, 15'd1, 15'd5); wait_for(p+1);
        chk("four_beat_u", q_nout[p], 15);

        // back-to-back frames, plus nsl clamping (3 -> 2, 0 -> 1)
        p = pulses;
        frame(4, 2'd1, 0, 0, 15'd1, 15'd0);
        frame(4, 2'd1, 0, 1, 15'd1, 15'd0);
        frame(1, 2'd3, 0, 0, 15'd1, 15'd1);
        frame(1, 2'd0, 0, 0, 15'd6, 15'd6);
        wait_for(p+4);
        chk("b2b_0", q_nout[p], 15);
        chk("b2b_1", q_nout[p+1], -1);
        chk("nsl_clamp_hi", q_nout[p+2], 4097);
        chk("nsl_clamp_zero", q_nout[p+3], 6);

        // 40 beats of 32767*4097: wraps to 2^51 - 2^40 - C, i.e. -(2^40 + C) signed
        ovf_exp = -(64'sd1 <<< 40) - 64'sd134246399;
        p = pulses; frame(40, 2'd2, 0, 0, 15'd32767, 15'd32767); wait_for(p+1);
        chk("ovf_nout", q_nout[p], ovf_exp);
        chk("ovf_flag", q_ovf[p], 1);
        p = pulses; frame(1, 2'd1, 0, 0, 15'd2, 15'd0); wait_for(p+1);
        chk("ovf_cleared_nout", q_nout[p], 2);
        chk("ovf_cleared_flag", q_ovf[p], 0);

        chk("perr_before", proto_err, 0);
        p = pulses;
        beat(0, 0, 2'd1, 0, 0, 15'd9, 15'd0);
        repeat (5) @(negedge clk);
        chk("orphan_no_out", pulses, p);
        chk("orphan_perr", proto_err, 1);

        p = pulses;
        beat(1, 0, 2'd1, 0, 0, 15'd1, 15'd0);
        beat(0, 0, 2'd1, 0, 0, 15'd1, 15'd0);
        beat(1, 0, 2'd1, 0, 0, 15'd9, 15'd0);
        beat(0, 1, 2'd1, 0, 0, 15'd0, 15'd0);
        wait_for(p+1);
        repeat (5) @(negedge clk);
        chk("inject_one_out", pulses, p+1);
        chk("inject_nout", q_nout[p], 18);

        p = pulses;
        beat(1, 0, 2'd1, 0, 0, 15'd1, 15'd0);
        beat(0, 0, 2'd1, 0, 0, 15'd1, 15'd0);
        rstn = 1'b0;
        #1;
        chk("midrst_nout", nout, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ovf", out_ovf, 0);
        chk("midrst_perr", proto_err, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_out", pulses, p);
        frame(4, 2'd1, 0, 0, 15'd1, 15'd0);
        wait_for(p+1);
        chk("post_rst_nout", q_nout[p], 15);
        chk("post_rst_perr", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
